// File: rtl/adma_desc_fetch_pkg.sv
// Shared definitions for the ADMA descriptor fetch/decode stage.
// Holds attribute bit positions, action codes, the descriptor geometry
// and the fetch FSM state encoding used by adma_desc_fetch and
// adma_desc_decode.
package adma_desc_fetch_pkg;

  // Attribute bits inside descriptor word0[5:0]
  localparam int ATTR_VALID  = 0;
  localparam int ATTR_END    = 1;
  localparam int ATTR_INT    = 2;
  localparam int ATTR_ACT_LO = 4;

  // Action codes carried in attr[5:4]
  localparam logic [1:0] ACT_NOP  = 2'b00;
  localparam logic [1:0] ACT_TRAN = 2'b01;
  localparam logic [1:0] ACT_RSV  = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  // Descriptor geometry: three little-endian-ordered 32-bit words
  localparam int DESC_BYTES_DFLT = 12;
  localparam int DESC_WORDS      = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_CAP    = 3'd2,
    ST_DECODE = 3'd3,
    ST_XFER   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/adma_desc_decode.sv
// Purely combinational ADMA descriptor decoder.
// Ports:
//   desc     in  96  descriptor {word2, word1, word0}
//   act      out 2   action code attr[5:4]
//   valid    out 1   attr valid bit
//   end_flag out 1   attr end bit
//   int_flag out 1   attr int bit
//   length   out 16  transfer length (0 encodes 65536)
//   addr     out 64  transfer / link address
//   bad      out 1   descriptor cannot be executed (not valid or reserved act)
module adma_desc_decode
  import adma_desc_fetch_pkg::*;
(
  input  logic [95:0] desc,
  output logic [1:0]  act,
  output logic        valid,
  output logic        end_flag,
  output logic        int_flag,
  output logic [15:0] length,
  output logic [63:0] addr,
  output logic        bad
);

  logic [31:0] word0;
  logic [5:0]  attr;
  logic        unused_bits;

  assign word0    = desc[31:0];
  assign attr     = word0[5:0];
  assign act      = attr[ATTR_ACT_LO +: 2];
  assign valid    = attr[ATTR_VALID];
  assign end_flag = attr[ATTR_END];
  assign int_flag = attr[ATTR_INT];
  assign length   = word0[31:16];
  assign addr     = desc[95:32];
  assign bad      = !valid || (act == ACT_RSV);

  // attr[3] and word0[15:6] are reserved and deliberately ignored
  assign unused_bits = ^{attr[3], word0[15:6]};

endmodule

// File: rtl/adma_desc_fetch.sv
// ADMA descriptor fetch/decode stage.
// Reads 96-bit descriptors from system RAM as three 32-bit words, decodes
// them and issues transfer commands to the data mover. Follows links, skips
// nops, stops on the end bit (done) or on a bad descriptor (error).
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   start, desc_base      begin a chain at desc_base (when not busy)
//   ram_address/ram_read  RAM read request; ram_write tied low
//   ram_data              RAM read data, valid the cycle after ram_read
//   xfer_valid/ready      transfer command handshake
//   xfer_addr/length/int  transfer command fields
//   busy, done, error     chain status; done/error are sticky
//   err_addr              address of the offending descriptor
module adma_desc_fetch
  import adma_desc_fetch_pkg::*;
#(
  parameter int DESC_BYTES = DESC_BYTES_DFLT,
  parameter int ADDR_W     = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] desc_base,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [31:0]       ram_data,
  output logic              xfer_valid,
  input  logic              xfer_ready,
  output logic [ADDR_W-1:0] xfer_addr,
  output logic [15:0]       xfer_length,
  output logic              xfer_int,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        k;
  logic [31:0]       word0, word1, word2;

  logic [1:0]        dec_act;
  logic              dec_valid, dec_end, dec_int, dec_bad;
  logic [15:0]       dec_length;
  logic [63:0]       dec_addr;

  logic              idle_like;
  logic              start_ok;
  logic              base_misaligned;
  logic [ADDR_W-1:0] ptr_next_desc;

  adma_desc_decode u_decode (
    .desc     ({word2, word1, word0}),
    .act      (dec_act),
    .valid    (dec_valid),
    .end_flag (dec_end),
    .int_flag (dec_int),
    .length   (dec_length),
    .addr     (dec_addr),
    .bad      (dec_bad)
  );

  assign idle_like       = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign start_ok        = idle_like && start;
  assign base_misaligned = (desc_base[1:0] != 2'b00);
  assign ptr_next_desc   = ptr + ADDR_W'(DESC_BYTES);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nxt = base_misaligned ? ST_ERR : ST_REQ;
      end
      ST_REQ: state_nxt = ST_CAP;
      ST_CAP: state_nxt = (k == 2'(DESC_WORDS - 1)) ? ST_DECODE : ST_REQ;
      ST_DECODE: begin
        if (!dec_valid || dec_bad) begin
          state_nxt = ST_ERR;
        end else begin
          case (dec_act)
            ACT_TRAN: state_nxt = ST_XFER;
            ACT_NOP:  state_nxt = dec_end ? ST_DONE : ST_REQ;
            ACT_LINK: begin
              if (dec_end)                  state_nxt = ST_DONE;
              else if (dec_addr[1:0] != 0)  state_nxt = ST_ERR;
              else                          state_nxt = ST_REQ;
            end
            default:  state_nxt = ST_ERR;
          endcase
        end
      end
      ST_XFER: begin
        if (xfer_ready) state_nxt = dec_end ? ST_DONE : ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Pointer, word capture and command/error registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr         <= '0;
      k           <= '0;
      word0       <= '0;
      word1       <= '0;
      word2       <= '0;
      xfer_addr   <= '0;
      xfer_length <= '0;
      xfer_int    <= 1'b0;
      err_addr    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_ok) begin
            ptr      <= desc_base;
            k        <= '0;
            err_addr <= base_misaligned ? desc_base : '0;
          end
        end
        ST_CAP: begin
          case (k)
            2'd0:    word0 <= ram_data;
            2'd1:    word1 <= ram_data;
            default: word2 <= ram_data;
          endcase
          k <= (k == 2'(DESC_WORDS - 1)) ? 2'd0 : k + 2'd1;
        end
        ST_DECODE: begin
          if (state_nxt == ST_ERR) begin
            err_addr <= ptr;
          end else if (dec_act == ACT_TRAN) begin
            xfer_addr   <= dec_addr;
            xfer_length <= dec_length;
            xfer_int    <= dec_int;
          end else if (state_nxt == ST_REQ) begin
            // nop advances to the next slot, link jumps to its target
            ptr <= (dec_act == ACT_LINK) ? dec_addr : ptr_next_desc;
          end
        end
        ST_XFER: begin
          if (xfer_ready && !dec_end) ptr <= ptr_next_desc;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; xfer_valid has no path from xfer_ready
  assign ram_read    = (state == ST_REQ);
  assign ram_address = (state == ST_REQ) ? (ptr + {{(ADDR_W-4){1'b0}}, k, 2'b00}) : '0;
  assign ram_write   = 1'b0;
  assign xfer_valid  = (state == ST_XFER);
  assign busy        = (state == ST_REQ) || (state == ST_CAP) ||
                       (state == ST_DECODE) || (state == ST_XFER);
  assign done        = (state == ST_DONE);
  assign error       = (state == ST_ERR);

endmodule

// File: tb/tb_adma_desc_fetch.sv
// Directed testbench for adma_desc_fetch with a small registered RAM model.
module tb_adma_desc_fetch;

  logic        CLK;
  logic        RESET;
  logic        start;
  logic [63:0] desc_base;
  logic [63:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_data;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [63:0] xfer_addr;
  logic [15:0] xfer_length;
  logic        xfer_int;
  logic        busy;
  logic        done;
  logic        error;
  logic [63:0] err_addr;

  int vectors;
  int miscompares;

  logic [31:0] mem [0:63];

  adma_desc_fetch dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .desc_base   (desc_base),
    .ram_address (ram_address),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_data    (ram_data),
    .xfer_valid  (xfer_valid),
    .xfer_ready  (xfer_ready),
    .xfer_addr   (xfer_addr),
    .xfer_length (xfer_length),
    .xfer_int    (xfer_int),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_addr    (err_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered RAM: data appears the cycle after the read strobe
  always @(posedge CLK) begin
    if (ram_read) ram_data <= mem[ram_address[7:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic put_desc(input int baddr, input logic [5:0] attr,
                          input logic [15:0] len, input logic [63:0] addr);
    mem[baddr/4]     = {len, 10'b0, attr};
    mem[baddr/4 + 1] = addr[31:0];
    mem[baddr/4 + 2] = addr[63:32];
  endtask

  task automatic do_start(input logic [63:0] base);
    desc_base = base;
    start     = 1'b1;
    cycle(1);
    start     = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  busy,        1'b0);
    chk({tag, "_xv"},    xfer_valid,  1'b0);
    chk({tag, "_rd"},    ram_read,    1'b0);
    chk({tag, "_ra"},    ram_address, 64'h0);
    chk({tag, "_xa"},    xfer_addr,   64'h0);
    chk({tag, "_xl"},    xfer_length, 64'h0);
    chk({tag, "_xi"},    xfer_int,    1'b0);
    chk({tag, "_done"},  done,        1'b0);
    chk({tag, "_err"},   error,       1'b0);
    chk({tag, "_ea"},    err_addr,    64'h0);
    chk({tag, "_wr"},    ram_write,   1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET       = 1'b1;
    start       = 1'b0;
    desc_base   = 64'h0;
    xfer_ready  = 1'b0;
    clear_mem();

    // Reset state
    cycle(2);
    RESET = 1'b0;
    cycle(1);
    chk_quiet("reset");

    // Two transfers then a link back to 0
    put_desc(0,  6'b010001, 16'd5, 64'd0);
    put_desc(12, 6'b010001, 16'd5, 64'd64);
    put_desc(24, 6'b110001, 16'd0, 64'd0);
    xfer_ready = 1'b1;
    do_start(64'd0);
    chk("t1_rd0", ram_read, 1'b1);
    chk("t1_ra0", ram_address, 64'd0);
    chk("t1_busy", busy, 1'b1);
    cycle(6);
    chk("t1_notyet", xfer_valid, 1'b0);
    cycle(1);
    chk("t1_xv0", xfer_valid, 1'b1);
    chk("t1_xa0", xfer_addr, 64'd0);
    chk("t1_xl0", xfer_length, 64'd5);
    cycle(1);
    chk("t1_ra12", ram_address, 64'd12);
    cycle(6);
    chk("t1_gap", xfer_valid, 1'b0);
    cycle(1);
    chk("t1_xv1", xfer_valid, 1'b1);
    chk("t1_xa1", xfer_addr, 64'd64);
    chk("t1_xl1", xfer_length, 64'd5);
    cycle(1);
    chk("t1_ra24", ram_address, 64'd24);
    cycle(6);
    cycle(1);
    chk("t1_link_rd", ram_read, 1'b1);
    chk("t1_link_ra", ram_address, 64'd0);
    cycle(7);
    chk("t1_xv2", xfer_valid, 1'b1);
    chk("t1_xa2", xfer_addr, 64'd0);
    chk("t1_xl2", xfer_length, 64'd5);
    chk("t1_done", done, 1'b0);
    // Reset while in XFER aborts the chain
    RESET = 1'b1;
    cycle(1);
    RESET = 1'b0;
    chk_quiet("t1_rst");

    // End bit on an invalid descriptor -> error
    clear_mem();
    put_desc(0,  6'b010001, 16'd80, 64'd24);
    put_desc(12, 6'b000010, 16'd0,  64'd0);
    do_start(64'd0);
    cycle(7);
    chk("t2_xv", xfer_valid, 1'b1);
    chk("t2_xa", xfer_addr, 64'd24);
    chk("t2_xl", xfer_length, 64'd80);
    cycle(7);
    chk("t2_pre_err", error, 1'b0);
    cycle(1);
    chk("t2_err", error, 1'b1);
    chk("t2_ea", err_addr, 64'd12);
    chk("t2_busy", busy, 1'b0);
    chk("t2_xv_off", xfer_valid, 1'b0);
    cycle(3);
    chk("t2_sticky", error, 1'b1);

    // Same chain, second descriptor is a valid tran with end
    put_desc(12, 6'b010011, 16'd7, 64'd200);
    do_start(64'd0);
    chk("t2b_errclr", error, 1'b0);
    chk("t2b_eaclr", err_addr, 64'd0);
    cycle(7);
    chk("t2b_xa0", xfer_addr, 64'd24);
    cycle(8);
    chk("t2b_xv1", xfer_valid, 1'b1);
    chk("t2b_xa1", xfer_addr, 64'd200);
    chk("t2b_xl1", xfer_length, 64'd7);
    cycle(1);
    chk("t2b_done", done, 1'b1);
    chk("t2b_busy", busy, 1'b0);
    chk("t2b_xv_off", xfer_valid, 1'b0);

    // Backpressure: command held, no RAM reads while waiting
    xfer_ready = 1'b0;
    do_start(64'd0);
    chk("t3_doneclr", done, 1'b0);
    cycle(7);
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      chk("t3_hold_xv", xfer_valid, 1'b1);
      chk("t3_hold_xa", xfer_addr, 64'd24);
      chk("t3_hold_xl", xfer_length, 64'd80);
      chk("t3_hold_rd", ram_read, 1'b0);
    end
    xfer_ready = 1'b1;
    cycle(1);
    chk("t3_resume_rd", ram_read, 1'b1);
    chk("t3_resume_ra", ram_address, 64'd12);
    cycle(7);
    chk("t3_xa1", xfer_addr, 64'd200);
    cycle(1);
    chk("t3_done", done, 1'b1);

    // Reset while a command is pending, then a normal restart
    xfer_ready = 1'b0;
    do_start(64'd0);
    cycle(7);
    chk("t4_pending", xfer_valid, 1'b1);
    RESET = 1'b1;
    cycle(1);
    RESET = 1'b0;
    chk_quiet("t4_rst_xfer");
    xfer_ready = 1'b1;
    do_start(64'd0);
    cycle(7);
    chk("t4_restart_xv", xfer_valid, 1'b1);
    chk("t4_restart_xa", xfer_addr, 64'd24);
    cycle(2);
    chk("t4_in_cap", ram_read, 1'b0);
    chk("t4_in_cap_busy", busy, 1'b1);
    // Reset during CAP with a simultaneous start: reset wins
    RESET = 1'b1;
    start = 1'b1;
    desc_base = 64'd0;
    cycle(1);
    RESET = 1'b0;
    start = 1'b0;
    chk_quiet("t4_rst_cap");
    cycle(2);
    chk("t4_idle_rd", ram_read, 1'b0);
    chk("t4_idle_busy", busy, 1'b0);

    // Nop then tran with int, length 0, end
    clear_mem();
    put_desc(0,  6'b000001, 16'd0, 64'd0);
    put_desc(12, 6'b010111, 16'd0, 64'd128);
    do_start(64'd0);
    cycle(7);
    chk("t5_nop_rd", ram_read, 1'b1);
    chk("t5_nop_ra", ram_address, 64'd12);
    cycle(7);
    chk("t5_xv", xfer_valid, 1'b1);
    chk("t5_xa", xfer_addr, 64'd128);
    chk("t5_xl", xfer_length, 64'd0);
    chk("t5_xi", xfer_int, 1'b1);
    cycle(1);
    chk("t5_done", done, 1'b1);
    chk("t5_xv_off", xfer_valid, 1'b0);

    // Reserved action
    clear_mem();
    put_desc(0, 6'b100001, 16'd4, 64'd0);
    do_start(64'd0);
    cycle(7);
    chk("t6_rsv_err", error, 1'b1);
    chk("t6_rsv_ea", err_addr, 64'd0);
    chk("t6_rsv_xv", xfer_valid, 1'b0);

    // Link to a misaligned address
    put_desc(36, 6'b110001, 16'd0, 64'd6);
    do_start(64'd36);
    chk("t6_link_clr", error, 1'b0);
    cycle(7);
    chk("t6_link_err", error, 1'b1);
    chk("t6_link_ea", err_addr, 64'd36);

    // Misaligned base: immediate error, no RAM read
    do_start(64'd2);
    chk("t6_base_err", error, 1'b1);
    chk("t6_base_ea", err_addr, 64'd2);
    chk("t6_base_rd", ram_read, 1'b0);
    chk("t6_base_busy", busy, 1'b0);
    cycle(3);
    chk("t6_base_rd2", ram_read, 1'b0);
    chk("t6_base_sticky", error, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
